uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one UART transmitter (wr/data/empty byte interface) between N_REQ byte producers.
- Arbitration is round-robin; each grant transmits one character.
- A requester holding `lock` keeps ownership for back-to-back characters, e.g. a multi-byte packet.
- Sits between the producers (CPU port, debug monitor, etc.) and the single tx instance driving serialOut.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 8, character width.
- WR_TIMEOUT, 4, max cycles to wait for tx_empty to fall after a write before flagging an error.

Ports:
- clk  in  1  system clock, all logic on posedge.
- res  in  1  asynchronous reset, active-high.
- req  in  N_REQ  per-requester transmit request.
- lock  in  N_REQ  per-requester hold-ownership request.
- req_data  in  N_REQ*DATA_W  requester i's character at bits [i*DATA_W +: DATA_W].
- ack  out  N_REQ  one-cycle pulse: requester's character accepted.
- grant_id  out  3  index of current/last owner.
- tx_wr  out  1  write strobe to transmitter.
- tx_data  out  DATA_W  character to transmitter.
- tx_empty  in  1  transmitter idle/ready (high = can accept).
- busy  out  1  arbiter not IDLE.
- err  out  1  sticky: tx_empty failed to fall within WR_TIMEOUT cycles of tx_wr.

Behaviour:
Reset values (asynchronous, while res=1):
- Outputs: tx_wr=0, tx_data=0, ack=0, grant_id=0, busy=0, err=0.
- Internal: state=IDLE, rr pointer last=N_REQ-1 (requester 0 wins first).

States are IDLE, ISSUE, WAIT_LOW, WAIT_HIGH.

IDLE:
- Arbitrates when tx_empty=1 and |req.
- Winner g is the first set req bit searching from (last+1) mod N_REQ upward, wrapping.
- On the same edge: tx_data<=req_data[g], grant_id<=g, go ISSUE.
- If tx_empty=0, stay in IDLE even with requests pending.

ISSUE (exactly one cycle):
- tx_wr=1 and ack[g]=1; every other ack bit stays 0.
- Go WAIT_LOW.
- Latency: req sampled in IDLE produces tx_wr on the next cycle.

WAIT_LOW:
- Wait for tx_empty=0, then go WAIT_HIGH.
- A counter, cleared on entry, counts cycles here.
- If it reaches WR_TIMEOUT: set err=1, set last<=g, go IDLE (character assumed lost).

WAIT_HIGH:
- Wait for tx_empty=1.
- If lock[g]=1 and req[g]=1 when tx_empty rises: latch tx_data<=req_data[g] and go ISSUE directly; no arbitration, grant_id and last unchanged.
- Otherwise: last<=g and go IDLE. New arbitration happens in IDLE the following cycle.

Output rules:
- tx_wr and ack are high only in ISSUE.
- tx_data holds its value until the next latch.
- busy = (state != IDLE).
- err is cleared only by res.

Protocol and boundary conditions:
- A requester keeps req and req_data stable until its ack. After ack it may change data, or drop req, on the next cycle.
- Requests not granted are ignored; dropping them has no effect.
- Simultaneous requests are resolved purely by rr order. With all N_REQ requesting continuously, no requester waits more than N_REQ-1 characters, unless a lock holder is active.
- lock without req grants nothing; lock is evaluated only for the current owner.
- The rr pointer wraps from N_REQ-1 to 0.
- res mid-character returns to IDLE immediately with tx_wr=0. The transmitter is reset by the same system reset.

Test Plan:
1. Single request: req=0001, req_data[0]=8'h41, tx_empty=1. Expect tx_wr and ack[0] for exactly one cycle, the cycle after req is sampled; tx_data=8'h41; grant_id=0; busy until tx_empty re-rises.
2. Round-robin: req=1111 held with data 8'hA0..8'hA3, tx model drops empty 1 cycle after wr and raises it 10 cycles later. Grant order must be 0,1,2,3,0; each ack a single pulse.
3. Lock burst: req=0011 with lock[1]=1 and requester 1 supplying 3 bytes 8'h10,8'h11,8'h12 while owning. Requester 0 then also sends 8'h01. Expect 8'h10,8'h11,8'h12 back-to-back, then requester 0's byte 8'h01; last=1 after the burst.
4. Not-ready transmitter: tx_empty=0 at reset release with req=0100. Expect no tx_wr until tx_empty=1, then grant_id=2.
5. Timeout: tx model ignores wr (tx_empty stays 1). Expect err=1 exactly WR_TIMEOUT cycles after ISSUE, return to IDLE, next request still served, err still 1.
6. Reset mid-operation: assert res during WAIT_HIGH. Expect immediate tx_wr=0, ack=0, busy=0, err=0, grant_id=0. After release, req=1000 and req=0001 together grant requester 0 first.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between N_REQ character producers.
// Round-robin arbitration, one character per grant; a `lock` holder keeps ownership
// for back-to-back characters. Write-to-accept handshake is watched by a timeout.
// Ports:
//   clk, res            clock, asynchronous active-high reset
//   req/lock/req_data   per-requester request, hold-ownership, character
//   ack                 one-cycle pulse to the requester whose character is written
//   grant_id            current/last owner index
//   tx_wr/tx_data       write strobe and character to the transmitter
//   tx_empty            transmitter ready (high = can accept)
//   busy                arbiter not idle
//   err                 sticky: transmitter did not take a written character in time
module uart_tx_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_W     = 8,
  parameter int WR_TIMEOUT = 4
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        lock,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        ack,
  output logic [2:0]              grant_id,
  output logic                    tx_wr,
  output logic [DATA_W-1:0]       tx_data,
  input  logic                    tx_empty,
  output logic                    busy,
  output logic                    err
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(WR_TIMEOUT + 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ISSUE     = 2'd1;
  localparam logic [1:0] S_WAIT_LOW  = 2'd2;
  localparam logic [1:0] S_WAIT_HIGH = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [IW-1:0]     gnt_q, gnt_d;
  logic [IW-1:0]     last_q, last_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;

  // Per-requester view of the flat character bus.
  logic [DATA_W-1:0] chan_dat [N_REQ];
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_chan
    assign chan_dat[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  // Round-robin pick: scan offsets from the far end back to last+1 so the
  // closest set request after the previous owner is the one that sticks.
  logic          win_vld;
  logic [IW-1:0] win_id;
  logic [IW:0]   rr_idx;

  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    rr_idx  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      rr_idx = {1'b0, last_q} + (IW+1)'(k);
      if (rr_idx >= (IW+1)'(N_REQ)) begin
        rr_idx = rr_idx - (IW+1)'(N_REQ);
      end
      if (req[rr_idx[IW-1:0]]) begin
        win_vld = 1'b1;
        win_id  = rr_idx[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (tx_empty && win_vld) begin
          gnt_d   = win_id;
          data_d  = chan_dat[win_id];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        // A falling tx_empty wins over an expiring count in the same cycle.
        if (!tx_empty) begin
          state_d = S_WAIT_HIGH;
        end else if (cnt_q == CW'(WR_TIMEOUT - 1)) begin
          // Character is assumed lost; rotate past this owner.
          err_d   = 1'b1;
          last_d  = gnt_q;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_HIGH: begin
        if (tx_empty) begin
          if (lock[gnt_q] && req[gnt_q]) begin
            // Locked owner continues without re-arbitration.
            data_d  = chan_dat[gnt_q];
            state_d = S_ISSUE;
          end else begin
            last_d  = gnt_q;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      last_q  <= IW'(N_REQ - 1);
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      ack[i] = (state_q == S_ISSUE) && (gnt_q == IW'(i));
    end
  end

  assign tx_wr    = (state_q == S_ISSUE);
  assign tx_data  = data_q;
  assign grant_id = 3'(gnt_q);
  assign busy     = (state_q != S_IDLE);
  assign err      = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios plus randomized traffic for uart_tx_arbiter.
// A behavioural arbiter model and a transmitter model live in the bench; a negedge
// process compares every DUT output with the model each cycle.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int W  = 4;

  logic            clk = 1'b0;
  logic            res = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    lock = '0;
  logic [N*DW-1:0] req_data = '0;
  logic            tx_empty = 1'b1;
  logic [N-1:0]    ack;
  logic [2:0]      grant_id;
  logic            tx_wr;
  logic [DW-1:0]   tx_data;
  logic            busy;
  logic            err;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .WR_TIMEOUT(W)) dut (
    .clk(clk), .res(res), .req(req), .lock(lock), .req_data(req_data),
    .ack(ack), .grant_id(grant_id), .tx_wr(tx_wr), .tx_data(tx_data),
    .tx_empty(tx_empty), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural arbiter model ----------------
  bit          m_busy, m_wr, m_fell, m_err;
  int          m_age, m_owner, m_last;
  logic [7:0]  m_data;

  function automatic int rr_pick(input int last_i, input logic [N-1:0] r);
    int pick;
    pick = -1;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last_i + k) % N;
      if (r[idx] && pick < 0) pick = idx;
    end
    return pick;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_wr = 0; m_fell = 0; m_err = 0;
    m_age = 0; m_owner = 0; m_last = N - 1; m_data = '0;
  endtask

  // One clock edge worth of the arbiter's rules, using the inputs seen before it.
  task automatic model_step();
    int g;
    if (res) begin
      model_reset();
      return;
    end
    if (!m_busy) begin
      if (tx_empty && (|req)) begin
        g = rr_pick(m_last, req);
        m_owner = g;
        m_data  = req_data[g*DW +: DW];
        m_busy  = 1;
        m_wr    = 1;
      end
    end else if (m_wr) begin
      m_wr = 0; m_fell = 0; m_age = 0;
    end else if (!m_fell) begin
      m_age++;
      if (!tx_empty) m_fell = 1;
      else if (m_age == W) begin
        m_err = 1; m_last = m_owner; m_busy = 0;
      end
    end else if (tx_empty) begin
      if (lock[m_owner] && req[m_owner]) begin
        m_data = req_data[m_owner*DW +: DW];
        m_wr   = 1;
      end else begin
        m_last = m_owner; m_busy = 0;
      end
    end
  endtask

  bit chk_on = 1'b1;
  always @(negedge clk) begin
    if (chk_on) begin
      check("tx_wr", 32'(tx_wr), 32'(m_wr));
      check("ack", 32'(ack), m_wr ? (32'd1 << m_owner) : 32'd0);
      check("tx_data", 32'(tx_data), 32'(m_data));
      check("grant_id", 32'(grant_id), 32'(m_owner));
      check("busy", 32'(busy), 32'(m_busy));
      check("err", 32'(err), 32'(m_err));
    end
  end

  // ---------------- requester feeds ----------------
  logic [7:0] fbuf [N][64];
  int         fhead [N];
  int         ftail [N];
  bit         lock_mode [N];

  task automatic apply_inputs();
    for (int i = 0; i < N; i++) begin
      req[i] = (fhead[i] != ftail[i]);
      req_data[i*DW +: DW] = req[i] ? fbuf[i][fhead[i] % 64] : 8'h00;
      lock[i] = lock_mode[i];
    end
  endtask

  task automatic push(input int i, input logic [7:0] b);
    fbuf[i][ftail[i] % 64] = b;
    ftail[i]++;
    apply_inputs();
  endtask

  function automatic bit feeds_empty();
    bit e;
    e = 1;
    for (int i = 0; i < N; i++) if (fhead[i] != ftail[i]) e = 0;
    return e;
  endfunction

  // ---------------- transmitter model ----------------
  bit s_wr;
  logic [N-1:0] s_ack;
  bit tx_ignore = 0, tx_hold_low = 0, rand_tx = 0;
  int fall_in = 0, low_left = 0, fall_dly = 1, rise_dly = 10;

  task automatic tx_step();
    int r;
    if (tx_hold_low) begin
      tx_empty = 1'b0; fall_in = 0; low_left = 0;
    end else if (res) begin
      tx_empty = 1'b1; fall_in = 0; low_left = 0;
    end else begin
      if (s_wr && !tx_ignore) begin
        if (rand_tx) begin
          r = int'($urandom_range(0, 7));
          fall_dly = (r == 0) ? W + 1 : (r == 1) ? W : 1;
          rise_dly = int'($urandom_range(1, 6));
        end
        fall_in = fall_dly;
        low_left = 0;
      end
      if (fall_in > 0) begin
        fall_in--;
        if (fall_in == 0) begin
          tx_empty = 1'b0;
          low_left = rise_dly;
        end
      end else if (low_left > 0) begin
        low_left--;
        if (low_left == 0) tx_empty = 1'b1;
      end
    end
  endtask

  // ---------------- cycle driver and log ----------------
  int         cyc = 0;
  int         err_first = -1;
  int         log_gid [$];
  int         log_cyc [$];
  logic [7:0] log_dat [$];
  logic [N-1:0] log_ack [$];

  task automatic log_clear();
    log_gid.delete(); log_cyc.delete(); log_dat.delete(); log_ack.delete();
  endtask

  task automatic cycle();
    @(negedge clk);
    s_wr  = tx_wr;
    s_ack = ack;
    if (tx_wr) begin
      log_gid.push_back(int'(grant_id));
      log_dat.push_back(tx_data);
      log_ack.push_back(ack);
      log_cyc.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    tx_step();
    for (int i = 0; i < N; i++) if (s_ack[i] && fhead[i] != ftail[i]) fhead[i]++;
    apply_inputs();
    if (err && err_first < 0) err_first = cyc;
  endtask

  task automatic do_reset(input int n);
    res = 1'b1;
    model_reset();
    for (int i = 0; i < N; i++) begin
      fhead[i] = 0; ftail[i] = 0; lock_mode[i] = 0;
    end
    apply_inputs();
    fall_in = 0; low_left = 0;
    tx_empty = !tx_hold_low;
    repeat (n) cycle();
    res = 1'b0;
  endtask

  task automatic run_until_idle(input int budget, input string name);
    int n;
    n = 0;
    while (n < budget && !(feeds_empty() && !busy && tx_empty)) begin
      cycle();
      n++;
    end
    check(name, 32'(n < budget), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    model_reset();
    do_reset(3);
    // Reset values.
    check("rst_tx_wr", 32'(tx_wr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_gid", 32'(grant_id), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);

    // 1: single request, one-cycle latency.
    log_clear();
    cycle();
    c0 = cyc;
    push(0, 8'h41);
    run_until_idle(60, "s1_drain");
    check("s1_count", 32'(log_gid.size()), 32'd1);
    check("s1_lat", 32'(log_cyc[0] - c0), 32'd1);
    check("s1_data", 32'(log_dat[0]), 32'h41);
    check("s1_gid", 32'(log_gid[0]), 32'd0);
    check("s1_ack", 32'(log_ack[0]), 32'b0001);

    // 2: round robin with all four requesting.
    do_reset(2);
    log_clear();
    push(0, 8'hA0); push(0, 8'hA0);
    push(1, 8'hA1); push(2, 8'hA2); push(3, 8'hA3);
    run_until_idle(200, "s2_drain");
    check("s2_count", 32'(log_gid.size()), 32'd5);
    for (int k = 0; k < 5; k++) begin
      check("s2_gid", 32'(log_gid[k]), 32'(k % 4));
      check("s2_data", 32'(log_dat[k]), 32'hA0 + 32'(k % 4));
      check("s2_ack", 32'(log_ack[k]), 32'd1 << (k % 4));
    end

    // 3: lock burst from requester 1, then requester 0.
    log_clear();
    lock_mode[1] = 1;
    push(1, 8'h10); push(1, 8'h11); push(1, 8'h12);
    push(0, 8'h01);
    run_until_idle(200, "s3_drain");
    lock_mode[1] = 0;
    apply_inputs();
    check("s3_count", 32'(log_gid.size()), 32'd4);
    check("s3_d0", 32'(log_dat[0]), 32'h10);
    check("s3_d1", 32'(log_dat[1]), 32'h11);
    check("s3_d2", 32'(log_dat[2]), 32'h12);
    check("s3_d3", 32'(log_dat[3]), 32'h01);
    check("s3_g2", 32'(log_gid[2]), 32'd1);
    check("s3_g3", 32'(log_gid[3]), 32'd0);
    check("s3_gap_lock", 32'(log_cyc[1] - log_cyc[0]), 32'd12);
    check("s3_gap_rearb", 32'(log_cyc[3] - log_cyc[2]), 32'd13);

    // 4: transmitter not ready at reset release.
    tx_hold_low = 1;
    do_reset(2);
    log_clear();
    push(2, 8'h5A);
    repeat (8) cycle();
    check("s4_nowr", 32'(log_gid.size()), 32'd0);
    tx_hold_low = 0;
    tx_empty = 1'b1;
    run_until_idle(60, "s4_drain");
    check("s4_count", 32'(log_gid.size()), 32'd1);
    check("s4_gid", 32'(log_gid[0]), 32'd2);

    // 5: transmitter ignores writes -> timeout, sticky err.
    tx_ignore = 1;
    log_clear();
    err_first = -1;
    push(3, 8'h33);
    run_until_idle(60, "s5_drain");
    check("s5_count", 32'(log_gid.size()), 32'd1);
    check("s5_err_lat", 32'(err_first - log_cyc[0]), 32'(W + 1));
    push(0, 8'h44);
    run_until_idle(60, "s5_drain2");
    check("s5_count2", 32'(log_gid.size()), 32'd2);
    check("s5_next_data", 32'(log_dat[1]), 32'h44);
    check("s5_err_sticky", 32'(err), 32'd1);
    tx_ignore = 0;

    // 6: reset while waiting for the transmitter to finish.
    log_clear();
    push(1, 8'h55);
    for (int k = 0; k < 30 && log_gid.size() == 0; k++) cycle();
    repeat (4) cycle();
    check("s6_pre_busy", 32'(busy), 32'd1);
    res = 1'b1;
    #1;
    check("s6_tx_wr", 32'(tx_wr), 32'd0);
    check("s6_ack", 32'(ack), 32'd0);
    check("s6_busy", 32'(busy), 32'd0);
    check("s6_err", 32'(err), 32'd0);
    check("s6_gid", 32'(grant_id), 32'd0);
    do_reset(2);
    log_clear();
    push(3, 8'h66);
    push(0, 8'h77);
    run_until_idle(100, "s6_drain");
    check("s6_first_gid", 32'(log_gid[0]), 32'd0);
    check("s6_first_dat", 32'(log_dat[0]), 32'h77);
    check("s6_second_gid", 32'(log_gid[1]), 32'd3);

    // Randomized traffic with random transmitter timing and lock use.
    rand_tx = 1;
    repeat (2000) begin
      int i;
      cycle();
      if ($urandom_range(0, 5) == 0) begin
        i = int'($urandom_range(0, N - 1));
        if (ftail[i] - fhead[i] < 4) push(i, 8'($urandom));
      end
      if ($urandom_range(0, 49) == 0) begin
        i = int'($urandom_range(0, N - 1));
        lock_mode[i] = ~lock_mode[i];
        apply_inputs();
      end
    end
    for (int i = 0; i < N; i++) lock_mode[i] = 0;
    apply_inputs();
    run_until_idle(600, "rand_drain");

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
